// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU load/store
// path and the host preload/readback port. At most one side is granted per
// cycle; the losing CPU access is stalled; read data returns registered with
// a one-cycle valid pulse on the winner's side.
//
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration. Without
// it, the CPU has fixed priority and a host that has lost STARVE consecutive
// cycles is forced to win.
module dmem_arbiter #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int STARVE = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic          cpu_gnt_s;
  logic          host_gnt_s;
  logic          host_prio_s;
  logic          cpu_rvalid_r;
  logic          host_rvalid_r;
  logic [DW-1:0] cpu_rdata_r;
  logic [DW-1:0] host_rdata_r;

`ifdef DMEM_ARB_RR_EN
  // 1 = host took the most recent grant, 0 = CPU (reset value)
  logic last_host_r;
`else
  // Starvation limit fits the 4-bit counter (legal STARVE is 1..15)
  localparam logic [3:0] STARVE_LIM = 4'(STARVE);
  logic [3:0] wait_cnt_r;
`endif

  // Decide which side wins when both request in the same cycle
  always_comb begin
`ifdef DMEM_ARB_RR_EN
    host_prio_s = ~last_host_r;
`else
    host_prio_s = (wait_cnt_r == STARVE_LIM);
`endif
  end

  // Grant generation; nothing is granted while reset is held low
  always_comb begin
    cpu_gnt_s  = 1'b0;
    host_gnt_s = 1'b0;
    if (!reset) begin
      cpu_gnt_s  = 1'b0;
      host_gnt_s = 1'b0;
    end else if (cpu_req && host_req) begin
      cpu_gnt_s  = ~host_prio_s;
      host_gnt_s = host_prio_s;
    end else begin
      cpu_gnt_s  = cpu_req;
      host_gnt_s = host_req;
    end
  end

  // Memory port mux: winner drives address/data; idle cycles park on cpu_addr
  always_comb begin
    mem_wr_en = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = {DW{1'b0}};
    if (host_gnt_s) begin
      mem_wr_en = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else if (cpu_gnt_s) begin
      mem_wr_en = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else begin
      mem_wr_en = 1'b0;
      mem_addr  = cpu_addr;
      mem_wdata = {DW{1'b0}};
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Remember the side that won the latest grant for round-robin fairness
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_host_r <= 1'b0;
    end else if (host_gnt_s) begin
      last_host_r <= 1'b1;
    end else if (cpu_gnt_s) begin
      last_host_r <= 1'b0;
    end else begin
      last_host_r <= last_host_r;
    end
  end
`else
  // Count consecutive cycles the host has waited, saturating at the limit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_r <= 4'd0;
    end else if (host_req && !host_gnt_s) begin
      if (wait_cnt_r < STARVE_LIM) begin
        wait_cnt_r <= wait_cnt_r + 4'd1;
      end else begin
        wait_cnt_r <= STARVE_LIM;
      end
    end else begin
      wait_cnt_r <= 4'd0;
    end
  end
`endif

  // Capture read data for the granted reader and pulse its valid next cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rvalid_r  <= 1'b0;
      host_rvalid_r <= 1'b0;
      cpu_rdata_r   <= {DW{1'b0}};
      host_rdata_r  <= {DW{1'b0}};
    end else begin
      cpu_rvalid_r  <= cpu_gnt_s & ~cpu_we;
      host_rvalid_r <= host_gnt_s & ~host_we;
      if (cpu_gnt_s && !cpu_we) begin
        cpu_rdata_r <= mem_rdata;
      end else begin
        cpu_rdata_r <= cpu_rdata_r;
      end
      if (host_gnt_s && !host_we) begin
        host_rdata_r <= mem_rdata;
      end else begin
        host_rdata_r <= host_rdata_r;
      end
    end
  end

  assign cpu_stall   = cpu_req & ~cpu_gnt_s;
  assign host_gnt    = host_gnt_s;
  assign cpu_rdata   = cpu_rdata_r;
  assign cpu_rvalid  = cpu_rvalid_r;
  assign host_rdata  = host_rdata_r;
  assign host_rvalid = host_rvalid_r;

endmodule
